// File: rtl/wb_ctrl_pkg.sv
// Shared codes for the rd writeback path: writeback types, rd_mux
// selects and wb_ctrl state encodings, plus a writeback-type decoder.
package wb_ctrl_pkg;

    localparam int REG_LEN     = 5;
    localparam int WB_TYPE_LEN = 3;

    typedef enum logic [WB_TYPE_LEN-1:0] {
        WB_NONE = 3'd0,
        WB_IMM  = 3'd1,
        WB_PCP4 = 3'd2,
        WB_ALU  = 3'd3,
        WB_LOAD = 3'd4
    } wb_type_t;

    typedef enum logic [1:0] {
        RD_IMM  = 2'd0,
        RD_PCP4 = 2'd1,
        RD_ALU  = 2'd2,
        RD_MEM  = 2'd3
    } rd_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LINK      = 2'd1,
        LOAD_WAIT = 2'd2
    } state_t;

    // Codes 5..7 are reserved and behave as "no writeback".
    function automatic wb_type_t decode_wb(input logic [WB_TYPE_LEN-1:0] code);
        wb_type_t t;
        if (code > 3'd4) t = WB_NONE;
        else             t = wb_type_t'(code);
        return t;
    endfunction

endpackage

// File: rtl/wb_timer.sv
// Load-timeout counter: cleared on load accept, counts wait cycles.
// Ports: clk, rst (sync, active-high), clear, en -> expired (count==TIMEOUT-1).
module wb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb_ctrl.sv
// Writeback sequencer for the rd path: picks the rd_mux source, drives
// the reg_file write port, stalls the front end during link/load
// writebacks, flags load timeouts and counts writes and stall cycles.
// Ports: clk, rst (sync, active-high); instr_valid, wb_type, rd_addr,
// mem_rvalid in; rd_sel, rd_we, rd_waddr, stall, mem_err, wr_count,
// stall_count out.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    input  logic [WB_TYPE_LEN-1:0] wb_type,
    input  logic [REG_LEN-1:0]     rd_addr,
    input  logic                   mem_rvalid,
    output logic [1:0]             rd_sel,
    output logic                   rd_we,
    output logic [REG_LEN-1:0]     rd_waddr,
    output logic                   stall,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       wr_count,
    output logic [CNT_W-1:0]       stall_count
);

    state_t             state;
    state_t             next_state;
    logic [REG_LEN-1:0] pend_rd;
    logic [REG_LEN-1:0] next_pend;
    rd_sel_t            sel;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_expired;
    logic               set_err;

    wb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend_rd     <= '0;
            mem_err     <= 1'b0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            state       <= next_state;
            pend_rd     <= next_pend;
            if (set_err) mem_err <= 1'b1;
            wr_count    <= wr_count + CNT_W'(rd_we);
            stall_count <= stall_count + CNT_W'(stall);
        end
    end

    // Outputs are forced to their idle values while rst is high so
    // that nothing is written or counted in a reset cycle.
    always_comb begin
        next_state = state;
        next_pend  = pend_rd;
        sel        = RD_ALU;
        rd_we      = 1'b0;
        rd_waddr   = '0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        set_err    = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        case (decode_wb(wb_type))
                            WB_IMM: begin
                                sel      = RD_IMM;
                                rd_waddr = rd_addr;
                                rd_we    = (rd_addr != '0);
                            end
                            WB_ALU: begin
                                sel      = RD_ALU;
                                rd_waddr = rd_addr;
                                rd_we    = (rd_addr != '0);
                            end
                            WB_PCP4: begin
                                // Link to x0 is a plain jump: no writeback.
                                if (rd_addr != '0) begin
                                    next_pend  = rd_addr;
                                    next_state = LINK;
                                end
                            end
                            WB_LOAD: begin
                                // Stall even for x0 so the load completes.
                                next_pend  = rd_addr;
                                tmr_clr    = 1'b1;
                                next_state = LOAD_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end
                LINK: begin
                    sel        = RD_PCP4;
                    rd_we      = 1'b1;
                    rd_waddr   = pend_rd;
                    next_state = IDLE;
                end
                LOAD_WAIT: begin
                    sel = RD_MEM;
                    if (mem_rvalid) begin
                        rd_waddr   = pend_rd;
                        rd_we      = (pend_rd != '0);
                        next_state = IDLE;
                    end else if (tmr_expired) begin
                        set_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign rd_sel = sel;
    assign stall  = !rst && (state != IDLE);

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback sequencer for the rd path: decides, per accepted instruction, which rd_mux source feeds the register file, when reg_file writes, and to which register.
- Sequences multi-cycle writebacks (link address via the one-cycle-delayed PC, memory loads) and stalls the front end meanwhile.
- Sits between decode/control and the rd_mux + reg_file write port; also provides load-timeout error and performance counters.

Parameters:
TIMEOUT, 16, max cycles spent in LOAD_WAIT without mem_rvalid before abort; legal range 2..255
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, all state on posedge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  decoded instruction present this cycle
wb_type  in  3  WB_NONE/WB_IMM/WB_PCP4/WB_ALU/WB_LOAD (codes 0..4; 5..7 treated as WB_NONE)
rd_addr  in  5  destination register of the presented instruction
mem_rvalid  in  1  load data valid on rd_mem this cycle
rd_sel  out  2  to rd_mux: RD_IMM/RD_PCP4/RD_ALU/RD_MEM
rd_we  out  1  reg_file write enable
rd_waddr  out  5  reg_file write address
stall  out  1  front end must hold the current instruction/PC
mem_err  out  1  sticky: a load timed out
wr_count  out  CNT_W  number of rd_we cycles since reset
stall_count  out  CNT_W  number of stall cycles since reset

Behaviour:
- States: IDLE, LINK, LOAD_WAIT. Reset -> IDLE; timer 0; mem_err 0; both counters 0.
- Outputs in reset/idle with no write: rd_we=0, rd_sel=RD_ALU, rd_waddr=0, stall=0.
- stall = (state != IDLE). An instruction is accepted only when instr_valid && state==IDLE.
- Accept, WB_NONE: no write; stay IDLE.
- Accept, WB_IMM / WB_ALU: same-cycle write (latency 0): rd_sel=RD_IMM / RD_ALU, rd_waddr=rd_addr, rd_we=(rd_addr!=0); stay IDLE.
- Accept, WB_PCP4: rd_addr!=0 -> latch pend_rd, go LINK. rd_addr==0 -> no write, stay IDLE.
- LINK (exactly 1 cycle): rd_sel=RD_PCP4 (rd_mux supplies the delayed PC), rd_we=1, rd_waddr=pend_rd; -> IDLE.
- Accept, WB_LOAD: latch pend_rd (even if 0), clear timer, go LOAD_WAIT. mem_rvalid in the accept cycle is ignored; a response needs at least 1 cycle.
- LOAD_WAIT, mem_rvalid=1: rd_sel=RD_MEM, rd_waddr=pend_rd, rd_we=(pend_rd!=0); -> IDLE.
- LOAD_WAIT, mem_rvalid=0: timer increments. When timer==TIMEOUT-1 with no rvalid: no write, mem_err<=1 (sticky until rst), -> IDLE. Maximum stall = TIMEOUT cycles.
- mem_rvalid while IDLE or LINK: ignored (late/stale response); no write, no error.
- rd_sel holds RD_MEM for the whole of LOAD_WAIT and RD_PCP4 in LINK; rd_we only as stated.
- x0 is never written.
- Counters: wr_count += rd_we; stall_count += stall; both wrap modulo 2^CNT_W.
- rst mid-LOAD_WAIT or mid-LINK: next cycle IDLE, pending write dropped, mem_err and counters cleared. A later mem_rvalid is ignored.
- rst has priority over every event in the same cycle.

Decomposition:
- rysy_pkg.vh: REG_LEN (existing); add WB_TYPE_LEN=3 and WB_NONE..WB_LOAD codes.
- rd_mux.vh: RD_IMM/RD_PCP4/RD_ALU/RD_MEM codes, reused unchanged.
- wb_ctrl.vh: state encodings.
- Sub-module: wb_timer (load-timeout counter: clear, enable, expired at TIMEOUT-1). Perf counters stay inline.

Test Plan:
- Reset, then ALU to x5 -> same cycle rd_sel=RD_ALU, rd_we=1, rd_waddr=5, stall=0; wr_count=1 next cycle.
- IMM to x0 -> rd_we=0, rd_sel=RD_IMM; wr_count unchanged; back-to-back ALU to x7 next cycle accepted.
- PCP4 to x1 -> cycle+1: stall=1, rd_sel=RD_PCP4, rd_we=1, rd_waddr=1; cycle+2: IDLE; stall_count=1.
- LOAD to x10, mem_rvalid at cycle+3 -> stall=1 for cycles+1..+3, write at +3 with RD_MEM/addr 10; stall_count=3; mem_err=0.
- LOAD to x3 with TIMEOUT=4 and no rvalid -> mem_err=1 after 4 stall cycles, no write; rvalid at cycle+6 -> ignored; mem_err stays 1.
- LOAD, rst asserted in cycle+2 -> cycle+3: IDLE, stall=0, counters 0; rvalid at cycle+3 -> no write.
